// File: rtl/logicnet_lut_layer_pipe.sv
// Pipelined layer of LogicNet LUT neurons with runtime-writable truth tables.
// Two stages: address capture, then table lookup into the output register.
module logicnet_lut_layer_pipe #(
  parameter int NUM_NEURONS = 4,
  parameter int FANIN       = 3,
  parameter int IN_BITS     = 2,
  parameter int OUT_BITS    = 2,
  localparam int ADDR_W     = FANIN * IN_BITS,
  localparam int NID_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  output logic                            cfg_ready,
  input  logic [NID_W-1:0]                cfg_neuron,
  input  logic [ADDR_W-1:0]               cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            cfg_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [OUT_BITS-1:0]             tbl [NUM_NEURONS][DEPTH];
  logic                            vld_p1;
  logic [NUM_NEURONS*ADDR_W-1:0]   addr_p1;
  logic [NUM_NEURONS*OUT_BITS-1:0] lut_p1;
  logic                            adv1;
  logic                            adv2;
  logic                            in_acc;
  logic                            wr_acc;
  logic                            nid_ok;

  function automatic logic nid_in_range(input logic [NID_W-1:0] nid);
    return int'(nid) < NUM_NEURONS;
  endfunction

  assign adv2      = !out_valid || out_ready;
  assign adv1      = !vld_p1 || adv2;
  // A pending table write blocks new input so the pipeline can drain first.
  assign in_ready  = adv1 && !cfg_we;
  assign in_acc    = in_valid && in_ready;
  assign cfg_ready = !vld_p1 && !out_valid;
  assign wr_acc    = cfg_we && cfg_ready;
  assign nid_ok    = nid_in_range(cfg_neuron);

  always_comb begin
    lut_p1 = '0;
    for (int n = 0; n < NUM_NEURONS; n++)
      lut_p1[n*OUT_BITS +: OUT_BITS] = tbl[n][addr_p1[n*ADDR_W +: ADDR_W]];
  end

  // Stage 0 -> 1: address capture
  always_ff @(posedge clk) begin
    if (in_acc) addr_p1 <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++)
        for (int a = 0; a < DEPTH; a++)
          tbl[n][a] <= '0;
    end else begin
      cfg_err <= wr_acc && !nid_ok;
      if (wr_acc && nid_ok) tbl[cfg_neuron][cfg_addr] <= cfg_data;
      if (adv1) vld_p1 <= in_acc;
      // Stage 1 -> 2: table lookup into output register
      if (adv2) begin
        out_valid <= vld_p1;
        if (vld_p1) out_data <= lut_p1;
      end
    end
  end

endmodule

// File: tb/tb_logicnet_lut_layer_pipe.sv
// Directed bench for logicnet_lut_layer_pipe built with three neurons so that
// neuron index 3 exercises the out-of-range configuration path.
module tb_logicnet_lut_layer_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_data;
  logic        cfg_we;
  logic        cfg_ready;
  logic [1:0]  cfg_neuron;
  logic [5:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logicnet_lut_layer_pipe #(
    .NUM_NEURONS(3), .FANIN(3), .IN_BITS(2), .OUT_BITS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  function automatic logic [17:0] mk(input logic [5:0] a0, input logic [5:0] a1,
                                     input logic [5:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d);
    cfg_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_data = d;
    #1;
    for (int k = 0; k < 20 && !cfg_ready; k++) step();
    if (!cfg_ready) begin
      n_bad++;
      $display("FAIL cfg_write_timeout cfg_ready=%b want 1", cfg_ready);
    end
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 6'd0) begin n_bad++; $display("FAIL rst_out_data got %h want 00", out_data); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_err got %b want 0", cfg_err); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cfg_ready got %b want 1", cfg_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_cleared_lookup();
    in_valid = 1'b1; in_data = mk(6'd32, 6'd0, 6'd0); out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_in_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_latency1 out_valid got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_latency2 out_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 6'd0) begin n_bad++; $display("FAIL clr_out_data got %h want 00", out_data); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [17:0] words [5];
    logic [5:0]  expv  [5];
    words = '{mk(6'd32, 6'd0, 6'd0), mk(6'd40, 6'd0, 6'd0), mk(6'd35, 6'd0, 6'd0),
              mk(6'd1, 6'd0, 6'd0), mk(6'd2, 6'd7, 6'd63)};
    expv  = '{6'b00_00_11, 6'b00_00_10, 6'b00_00_01, 6'b00_00_11, 6'b01_10_00};
    cfg_write(2'd0, 6'd32, 2'b11);
    cfg_write(2'd0, 6'd40, 2'b10);
    cfg_write(2'd0, 6'd35, 2'b01);
    cfg_write(2'd0, 6'd1,  2'b11);
    cfg_write(2'd1, 6'd7,  2'b10);
    cfg_write(2'd2, 6'd63, 2'b01);
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_err_valid_write got %b want 0", cfg_err); end
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 5);
      in_data  = (c < 5) ? words[c] : '0;
      #1;
      if (c < 5) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready c=%0d got %b want 1", c, in_ready); end
      end
      if (c < 2) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid c=%0d got %b want 0", c, out_valid); end
      end else begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_bubble c=%0d got %b want 1", c, out_valid); end
        n_cmp++; if (out_data !== expv[c-2]) begin n_bad++; $display("FAIL stream_data c=%0d got %b want %b", c, out_data, expv[c-2]); end
      end
      step();
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [17:0] words [5];
    logic [5:0]  expv  [5];
    logic [5:0]  q [$];
    logic [5:0]  held;
    logic        stalled;
    int          idx;
    words = '{mk(6'd32, 6'd0, 6'd0), mk(6'd40, 6'd0, 6'd0), mk(6'd35, 6'd0, 6'd0),
              mk(6'd1, 6'd0, 6'd0), mk(6'd2, 6'd7, 6'd63)};
    expv  = '{6'b00_00_11, 6'b00_00_10, 6'b00_00_01, 6'b00_00_11, 6'b01_10_00};
    idx = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 30 && (idx < 5 || q.size() > 0); c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (idx < 5);
      in_data   = (idx < 5) ? words[idx] : '0;
      #1;
      if (stalled) begin
        n_cmp++; if (out_data !== held) begin n_bad++; $display("FAIL bp_hold c=%0d got %b want %b", c, out_data, held); end
      end
      if (c >= 2 && c <= 4) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c=%0d got %b want 0", c, in_ready); end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra_word got %b want none", out_data);
        end else begin
          if (out_data !== q[0]) begin n_bad++; $display("FAIL bp_order got %b want %b", out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (in_valid && in_ready) begin q.push_back(expv[idx]); idx++; end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (idx != 5 || q.size() != 0) begin n_bad++; $display("FAIL bp_complete sent=%0d pending=%0d want 5/0", idx, q.size()); end
    step();
  endtask

  task automatic test_cfg_in_flight();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(6'd32, 6'd0, 6'd0);
    step();
    in_data = mk(6'd40, 6'd0, 6'd0);
    step();
    in_data = mk(6'd2, 6'd0, 6'd0);
    cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 6'd2; cfg_data = 2'b10;
    #1;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL flt_cfg_ready got %b want 0", cfg_ready); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flt_in_ready got %b want 0", in_ready); end
    step();
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL flt_cfg_ready_stall got %b want 0", cfg_ready); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_data !== 6'b00_00_11) begin n_bad++; $display("FAIL flt_word0 got %b want 000011", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flt_cfg_wins got %b want 0", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 6'b00_00_10) begin n_bad++; $display("FAIL flt_word1 got %b/%b want 1/000010", out_valid, out_data); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL flt_cfg_ready_drain got %b want 0", cfg_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || cfg_ready !== 1'b1) begin n_bad++; $display("FAIL flt_drained got valid=%b cfg_ready=%b want 0/1", out_valid, cfg_ready); end
    step();
    cfg_we = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flt_no_accept got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flt_in_ready_after got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 6'b00_00_10) begin n_bad++; $display("FAIL flt_new_entry got %b/%b want 1/000010", out_valid, out_data); end
    step();
  endtask

  task automatic test_cfg_err();
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_neuron = 2'd3; cfg_addr = 6'd32; cfg_data = 2'b00;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL err_cfg_ready got %b want 1", cfg_ready); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_before got %b want 0", cfg_err); end
    step();
    cfg_we = 1'b0;
    n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_pulse got %b want 1", cfg_err); end
    step();
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle got %b want 0", cfg_err); end
    in_valid = 1'b1; in_data = mk(6'd32, 6'd7, 6'd63);
    step();
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 6'b01_10_11) begin n_bad++; $display("FAIL err_tables_kept got %b/%b want 1/011011", out_valid, out_data); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = mk(6'd32, 6'd0, 6'd0);
    step();
    in_data = mk(6'd40, 6'd0, 6'd0);
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 6'd0) begin n_bad++; $display("FAIL rmid_out_data got %b want 000000", out_data); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_cfg_ready got %b want 1", cfg_ready); end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_stale got %b want 0", out_valid); end
    in_valid = 1'b1; in_data = mk(6'd32, 6'd7, 6'd63);
    step();
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 6'd0) begin n_bad++; $display("FAIL rmid_cleared got %b/%b want 1/000000", out_valid, out_data); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_cleared_lookup();
    test_stream();
    test_backpressure();
    test_cfg_in_flight();
    test_cfg_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
